// File: rtl/riscv_uop_pkg.sv
// Shared micro-op definitions: ALU operation encodings and arbiter sizing limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_uop_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_SLL  = 4'h2,
    ALU_SLT  = 4'h3,
    ALU_SLTU = 4'h4,
    ALU_XOR  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_OR   = 4'h8,
    ALU_AND  = 4'h9
  } alu_op_t;

  // Upper bound on requesters sharing one ALU through alu_rr_arbiter.
  localparam int ALU_ARB_MAX_REQ = 8;

  // Marker value returned for any encoding the ALU does not implement.
  localparam logic [31:0] ALU_BAD_RESULT = 32'h0BAD_C0DE;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU (RV32I register-register ops).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result follows the inputs.
module alu
  import riscv_uop_pkg::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  logic [4:0] shamt;

  assign shamt = op2[4:0];

  // Operation decode; unknown encodings yield the bad-result marker.
  always_comb begin
    result = ALU_BAD_RESULT;
    case (alu_op)
      ALU_ADD:  result = op1 + op2;
      ALU_SUB:  result = op1 - op2;
      ALU_SLL:  result = op1 << shamt;
      ALU_SLT:  result = {31'b0, $signed(op1) < $signed(op2)};
      ALU_SLTU: result = {31'b0, op1 < op2};
      ALU_XOR:  result = op1 ^ op2;
      ALU_SRL:  result = op1 >> shamt;
      ALU_SRA:  result = 32'($signed(op1) >>> shamt);
      ALU_OR:   result = op1 | op2;
      ALU_AND:  result = op1 & op2;
      default:  result = ALU_BAD_RESULT;
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters; result lands in a one-entry tagged output register.
// Latency: 1 cycle from request transfer to o_rsp_valid; 1 result/cycle while i_rsp_ready stays high.
// Backpressure: all o_req_ready bits drop while the output slot is full and i_rsp_ready is low.
// Optional ALU_ARB_PERF_EN adds o_grant_cnt, per-requester saturating 16-bit grant counters.
module alu_rr_arbiter
  import riscv_uop_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = ($clog2(NUM_REQ) > 0) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic [NUM_REQ-1:0][31:0]   i_req_op1,
  input  logic [NUM_REQ-1:0][31:0]   i_req_op2,
  input  alu_op_t [NUM_REQ-1:0]      i_req_alu_op,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [31:0]                o_rsp_result,
  output logic [ID_W-1:0]            o_rsp_id
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]   o_grant_cnt
`endif
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W:0]      pick;
  logic               win_any;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] grant;
  logic               slot_free;
  logic               transfer;
  logic [31:0]        alu_op1;
  logic [31:0]        alu_op2;
  alu_op_t            alu_sel_op;
  logic [31:0]        alu_result;

  // Scan from ptr upward with wrap; the lowest offset from ptr that is valid wins.
  // Walking offsets high-to-low lets the last hit be the winner without a found flag.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] sel;
    int            idx;
    sel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (vld[ID_W'(idx)]) begin
        sel = {1'b1, ID_W'(idx)};
      end
    end
    return sel;
  endfunction

  // Grant depends only on valids and pointer, never on request payloads.
  always_comb begin
    pick    = rr_pick(i_req_valid, rr_ptr);
    win_any = pick[ID_W];
    win_idx = pick[ID_W-1:0];
    grant   = '0;
    if (win_any) begin
      grant = NUM_REQ'(1) << win_idx;
    end
  end

  assign slot_free   = !o_rsp_valid || i_rsp_ready;
  assign o_req_ready = grant & {NUM_REQ{slot_free}} & {NUM_REQ{!i_rst}};
  assign transfer    = |(o_req_ready & i_req_valid);

  // Steer the winner's operands into the shared ALU.
  always_comb begin
    alu_op1    = i_req_op1[win_idx];
    alu_op2    = i_req_op2[win_idx];
    alu_sel_op = i_req_alu_op[win_idx];
  end

  alu u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .alu_op (alu_sel_op),
    .result (alu_result)
  );

  // Output slot and round-robin pointer; a transfer overwrites the slot even while it drains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_result <= '0;
      o_rsp_id     <= '0;
      rr_ptr       <= '0;
    end else if (transfer) begin
      o_rsp_valid  <= 1'b1;
      o_rsp_result <= alu_result;
      o_rsp_id     <= win_idx;
      rr_ptr       <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
    end else if (i_rsp_ready) begin
      o_rsp_valid  <= 1'b0;
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Per-requester grant counters, sticking at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_grant_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (i_req_valid[k] && o_req_ready[k] && (o_grant_cnt[k] != 16'hFFFF)) begin
          o_grant_cnt[k] <= o_grant_cnt[k] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one combinational `alu` instance among NUM_REQ requesters, for example the execute stage, branch-target AGU and CSR read-modify-write path. Arbitration is round-robin with valid/ready handshakes on every request port. The winning request's result is captured in a one-entry output register, tagged with the requester ID. The block sits between the issue logic and writeback/forwarding.

Parameters:
NUM_REQ, 2, number of requester ports (legal range 2..8)
ID_W, ($clog2(NUM_REQ) > 0 ? $clog2(NUM_REQ) : 1), width of the response ID tag

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous reset, active-high
i_req_valid  in  NUM_REQ  per-requester request valid
o_req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
i_req_op1  in  NUM_REQ x 32  operand 1 per requester
i_req_op2  in  NUM_REQ x 32  operand 2 per requester
i_req_alu_op  in  NUM_REQ x alu_op_t  operation per requester (riscv_uop_pkg)
o_rsp_valid  out  1  response register holds a valid result
i_rsp_ready  in  1  consumer accepts response
o_rsp_result  out  32  registered ALU result
o_rsp_id  out  ID_W  index of requester that produced o_rsp_result

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_rsp_valid=0, o_rsp_result=0, o_rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - o_req_ready reads all-zero while i_rst is high.
- Output slot free: slot_free = !o_rsp_valid || i_rsp_ready.
- Grant, combinational:
  - Scan i_req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first asserted index wins, giving a one-hot grant.
  - o_req_ready = grant & {NUM_REQ{slot_free}}.
  - o_req_ready must not depend on the winner's data inputs.
- Transfer: a request transfers when i_req_valid[k] && o_req_ready[k]. In that cycle:
  - The winner's op1/op2/alu_op are muxed into the `alu`.
  - On the clock edge: o_rsp_result <= alu result, o_rsp_id <= k, o_rsp_valid <= 1, rr_ptr <= (k+1) mod NUM_REQ.
- Latency: exactly 1 cycle from request transfer to o_rsp_valid.
- Throughput: 1 result per cycle while i_rsp_ready stays high.
- Response handshake:
  - A response completes when o_rsp_valid && i_rsp_ready.
  - If it completes with no new transfer in the same cycle, o_rsp_valid <= 0 and result/id hold their old values.
  - A completion and a new transfer in the same cycle overwrite the slot with the new result and keep valid=1. This is a pipelined pass-through, with no bubble.
- Backpressure:
  - While o_rsp_valid=1 and i_rsp_ready=0, every o_req_ready bit is 0.
  - o_rsp_result and o_rsp_id are held stable.
  - rr_ptr does not change.
- No request valid: rr_ptr holds and no transfer occurs.
- Fairness: a continuously asserted requester is granted within NUM_REQ transfers.
- Requester rule: a requester holds its valid and payload stable until ready is seen. The arbiter does not check this; the bench asserts it.
- Default/illegal alu_op: the result is whatever `alu` produces (0x0BADC0DE). It is passed through unchanged.
- Reset mid-operation: any in-flight response is dropped (valid=0) and pending requests are not acknowledged in that cycle.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- When defined, adds output o_grant_cnt (NUM_REQ x 16): per-requester grant counters.
  - A counter increments on each transfer for its index.
  - Counters saturate at 16'hFFFF.
  - Reset clears all counters to 0.
- When undefined, the port and counters do not exist and the remaining behaviour is identical.

Decomposition:
- riscv_uop_pkg (existing shared package): alu_op_t and the ALU_* encodings.
- New in riscv_uop_pkg: localparam ALU_ARB_MAX_REQ = 8.
- Sub-module: `alu`, instantiated once unchanged; its op1/op2/alu_op inputs are driven by the grant mux.
- Round-robin priority select: local function or always_comb inside alu_rr_arbiter. No separate module.

Test Plan:
- Single request: req0 ADD op1=5 op2=7, i_rsp_ready=1 -> next cycle rsp_valid=1, result=12, id=0; rr_ptr=1.
- Contention: req0 SUB 10-3 and req1 XOR 0xF0^0x0F held for 2 cycles, rr_ptr=0 -> cycle1 grants req0 (result 7, id 0), cycle2 grants req1 (result 0xFF, id 1).
- Backpressure: response valid (0x0000_0010, id 1), i_rsp_ready=0 for 3 cycles with req0 SLL 1<<4 pending -> ready=0 throughout and result/id held; ready released -> req0 transfers the same cycle and next result=0x10, id=0.
- Back-to-back: req1 streams SLTU (1<2, then 3<2), i_rsp_ready=1 -> results 1 then 0 on consecutive cycles with no bubble.
- Reset mid-flight: i_rsp_ready=0 with a response held, i_rst pulsed for 1 cycle -> rsp_valid=0, result=0, id=0; first grant after reset goes to req0 when req0 and req1 are both valid.
- ALU_ARB_PERF_EN: NUM_REQ=2, both requesters always valid for 10 transfers -> o_grant_cnt = {5,5}.
